// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request/response, memory-side and status signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline plus memory model.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;
   logic [31:0]       perf_if_stall;
   logic [31:0]       perf_d_stall;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, perf_if_stall, perf_d_stall
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, perf_if_stall, perf_d_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (MEM), data first with IF anti-starvation.
// Defining ARB_PERF_EN builds saturating stall-cycle counters; otherwise the perf ports read 0.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(MEM_LAT) + 1;
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [STV_W-1:0]  starve_r;
   logic              grant_d_r;
   logic              mem_en_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;
   logic              if_ack_r;
   logic              d_ack_r;

   logic cand_if_s;
   logic cand_d_s;
   logic pick_d_s;
   logic win_s;

   // Requests still waiting (the one being acked is excluded) and the arbitration winner
   always_comb begin
      cand_if_s = bus.if_req & ~if_ack_r;
      cand_d_s  = bus.d_req & ~d_ack_r;
      win_s     = cand_if_s | cand_d_s;
      pick_d_s  = 1'b0;
      if (cand_if_s && (starve_r == STV_MAX)) begin
         pick_d_s = 1'b0;
      end else begin
         pick_d_s = cand_d_s;
      end
   end

   // Access sequencer: arbitrate, hold the memory for MEM_LAT cycles, then pulse the winner's ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         starve_r    <= {STV_W{1'b0}};
         grant_d_r   <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         if_rdata_r  <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
         if_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
      end else begin
         if_ack_r <= 1'b0;
         d_ack_r  <= 1'b0;
         case (state_r)
            IDLE, RESP: begin
               cnt_r <= {CNT_W{1'b0}};
               if (win_s) begin
                  state_r     <= ACCESS;
                  grant_d_r   <= pick_d_s;
                  mem_en_r    <= 1'b1;
                  mem_we_r    <= pick_d_s & bus.d_we;
                  mem_addr_r  <= pick_d_s ? bus.d_addr : bus.if_addr;
                  mem_wdata_r <= pick_d_s ? bus.d_wdata : {DATA_W{1'b0}};
                  if (!pick_d_s) begin
                     starve_r <= {STV_W{1'b0}};
                  end else if (cand_if_s && (starve_r != STV_MAX)) begin
                     starve_r <= starve_r + STV_W'(1);
                  end
               end else begin
                  state_r  <= IDLE;
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
               end
            end
            ACCESS: begin
               if (cnt_r == CNT_LAST) begin
                  state_r  <= RESP;
                  cnt_r    <= {CNT_W{1'b0}};
                  mem_en_r <= 1'b0;
                  mem_we_r <= 1'b0;
                  if (grant_d_r) begin
                     d_ack_r <= 1'b1;
                     if (!mem_we_r) begin
                        d_rdata_r <= bus.mem_rdata;
                     end
                  end else begin
                     if_ack_r   <= 1'b1;
                     if_rdata_r <= bus.mem_rdata;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               mem_en_r <= 1'b0;
               mem_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.if_ack    = if_ack_r;
   assign bus.d_ack     = d_ack_r;
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.stall_if  = cand_if_s;
   assign bus.stall_mem = cand_d_s;

`ifdef ARB_PERF_EN
   logic [31:0] perf_if_r;
   logic [31:0] perf_d_r;

   // Saturating counts of cycles each stage spends stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_if_r <= 32'd0;
         perf_d_r  <= 32'd0;
      end else begin
         if (cand_if_s && (perf_if_r != 32'hFFFF_FFFF)) begin
            perf_if_r <= perf_if_r + 32'd1;
         end
         if (cand_d_s && (perf_d_r != 32'hFFFF_FFFF)) begin
            perf_d_r <= perf_d_r + 32'd1;
         end
      end
   end

   assign bus.perf_if_stall = perf_if_r;
   assign bus.perf_d_stall  = perf_d_r;
`else
   assign bus.perf_if_stall = 32'd0;
   assign bus.perf_d_stall  = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// all checked cycle by cycle against a transaction-level schedule model.
module tb_mem_port_arbiter;
   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Environment memory (driven by the DUT) and the model's own copy
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];
   assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr[9:2]] : 32'd0;
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
   end

   int checks   = 0;
   int failures = 0;

   // Schedule model: when the next arbitration happens, who holds the memory, when its ack is due
   int          cyc = 0;
   int          next_arb = 0;
   int          pend_ack = -1;
   int          starve = 0;
   bit          pend_d, pend_we;
   logic [31:0] pend_addr, pend_wdata;
   logic [31:0] exp_if_rdata = 32'd0;
   logic [31:0] exp_d_rdata  = 32'd0;
   logic [31:0] exp_pi = 32'd0;
   logic [31:0] exp_pd = 32'd0;
   bit          got_if_ack, got_d_ack;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_cycle();
      bit e_if_ack, e_d_ack, e_en, cand_i, cand_d, win_d;
      logic [7:0] idx;
      got_if_ack = 1'b0;
      got_d_ack  = 1'b0;
      if (!rst) begin
         chk1("rst_mem_en", bus.mem_en, 1'b0);
         chk1("rst_mem_we", bus.mem_we, 1'b0);
         chk1("rst_if_ack", bus.if_ack, 1'b0);
         chk1("rst_d_ack", bus.d_ack, 1'b0);
         chk32("rst_if_rdata", bus.if_rdata, 32'd0);
         chk32("rst_d_rdata", bus.d_rdata, 32'd0);
         chk32("rst_mem_addr", bus.mem_addr, 32'd0);
         chk32("rst_perf_if", bus.perf_if_stall, 32'd0);
         pend_ack = -1;
         next_arb = cyc + 1;
         starve = 0;
         exp_if_rdata = 32'd0;
         exp_d_rdata  = 32'd0;
         exp_pi = 32'd0;
         exp_pd = 32'd0;
         return;
      end
      e_if_ack = (pend_ack == cyc) && !pend_d;
      e_d_ack  = (pend_ack == cyc) && pend_d;
      e_en     = (pend_ack >= 0) && (cyc >= pend_ack - LAT) && (cyc < pend_ack);
      if (pend_ack == cyc) begin
         idx = pend_addr[9:2];
         if (!pend_d)      exp_if_rdata = ref_mem[idx];
         else if (pend_we) ref_mem[idx] = pend_wdata;
         else              exp_d_rdata = ref_mem[idx];
      end
      chk1("if_ack", bus.if_ack, e_if_ack);
      chk1("d_ack", bus.d_ack, e_d_ack);
      chk1("mem_en", bus.mem_en, e_en);
      chk1("mem_we", bus.mem_we, e_en & pend_we);
      if (e_en) chk32("mem_addr", bus.mem_addr, pend_addr);
      if (e_en && pend_we) chk32("mem_wdata", bus.mem_wdata, pend_wdata);
      chk32("if_rdata", bus.if_rdata, exp_if_rdata);
      chk32("d_rdata", bus.d_rdata, exp_d_rdata);
      chk1("stall_if", bus.stall_if, bus.if_req & ~e_if_ack);
      chk1("stall_mem", bus.stall_mem, bus.d_req & ~e_d_ack);
`ifdef ARB_PERF_EN
      chk32("perf_if", bus.perf_if_stall, exp_pi);
      chk32("perf_d", bus.perf_d_stall, exp_pd);
`else
      chk32("perf_if", bus.perf_if_stall, 32'd0);
      chk32("perf_d", bus.perf_d_stall, 32'd0);
`endif
      if (bus.if_req && !e_if_ack) exp_pi = exp_pi + 32'd1;
      if (bus.d_req && !e_d_ack)   exp_pd = exp_pd + 32'd1;
      got_if_ack = e_if_ack;
      got_d_ack  = e_d_ack;
      // Arbitration: data first unless IF has lost SMAX times in a row
      if (cyc == next_arb) begin
         cand_i = bus.if_req && !e_if_ack;
         cand_d = bus.d_req && !e_d_ack;
         if (cand_i || cand_d) begin
            win_d = cand_d && !(cand_i && starve == SMAX);
            if (!win_d)      starve = 0;
            else if (cand_i) starve = (starve < SMAX) ? starve + 1 : SMAX;
            pend_d     = win_d;
            pend_we    = win_d && bus.d_we;
            pend_addr  = win_d ? bus.d_addr : bus.if_addr;
            pend_wdata = bus.d_wdata;
            pend_ack   = cyc + LAT + 1;
            next_arb   = pend_ack;
         end else begin
            next_arb = cyc + 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // mode 0: only retire acked requests; 1: random new requests; 2: both masters always requesting
   task automatic run(input int n, input int mode);
      for (int k = 0; k < n; k++) begin
         step();
         if (got_if_ack) bus.if_req = 1'b0;
         if (got_d_ack)  bus.d_req  = 1'b0;
         if (mode != 0 && !bus.if_req && (mode == 2 || $urandom_range(0, 3) != 0)) begin
            bus.if_req  = 1'b1;
            bus.if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         end
         if (mode != 0 && !bus.d_req && (mode == 2 || $urandom_range(0, 2) == 0)) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bus.d_wdata = $urandom;
         end
      end
   endtask

   logic [31:0] p_if0, p_d0, w;

   initial begin
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         mem[i] = w;
         ref_mem[i] = w;
      end
      bus.if_req = 1'b1;  bus.if_addr = 32'h0;
      bus.d_req  = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = 32'h0;  bus.d_wdata = 32'h0;

      // Reset held with a fetch pending, then the fetch of 0x0
      run(2, 0);
      rst = 1'b1;
      run(6, 0);
      chk32("s1_if_rdata", bus.if_rdata, ref_mem[0]);

      // Simultaneous fetch and load: data first, then IF
      p_if0 = bus.perf_if_stall;
      p_d0  = bus.perf_d_stall;
      bus.if_req = 1'b1;  bus.if_addr = 32'h20;
      bus.d_req  = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h100;
      run(9, 0);
`ifdef ARB_PERF_EN
      chk32("s2_perf_if", bus.perf_if_stall - p_if0, 32'd6);
      chk32("s2_perf_d", bus.perf_d_stall - p_d0, 32'd3);
`else
      chk32("s2_perf_if", bus.perf_if_stall - p_if0, 32'd0);
      chk32("s2_perf_d", bus.perf_d_stall - p_d0, 32'd0);
`endif

      // Store to 0x40
      bus.d_req = 1'b1;  bus.d_we = 1'b1;  bus.d_addr = 32'h40;  bus.d_wdata = 32'hDEAD_BEEF;
      run(6, 0);
      chk32("s4_mem_word", mem[16], 32'hDEAD_BEEF);

      // Continuous data stream alongside fetches, then drain
      run(40, 2);
      run(10, 0);

      // Asynchronous reset during the second access cycle aborts the fetch
      bus.if_req = 1'b1;  bus.if_addr = 32'h80;
      run(2, 0);
      chk1("s5_mem_en_live", bus.mem_en, 1'b1);
      rst = 1'b0;
      #1;
      chk1("s5_mem_en_abort", bus.mem_en, 1'b0);
      chk1("s5_if_ack_abort", bus.if_ack, 1'b0);
      run(1, 0);
      rst = 1'b1;
      run(6, 0);
      chk32("s5_if_rdata", bus.if_rdata, ref_mem[32]);

      // Random traffic
      run(600, 1);
      run(10, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
